vram_write_coalescer: RTL and testbench
=======================================

VRAM_WRITE_COALESCER -- requirements
Module: vram_write_coalescer

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16, meaning pixel address width.
REQ-002 SHALL have parameter PIXEL_WIDTH, default 16, meaning pixel data width.
REQ-003 SHALL have parameter VRAM_DATA_WIDTH, default 64, meaning VRAM word width; must be PIXEL_WIDTH times a power of two, giving PPW = VRAM_DATA_WIDTH/PIXEL_WIDTH lanes and L = log2(PPW).
REQ-004 SHALL have parameter FLUSH_TIMEOUT, default 15, meaning idle cycles before auto-flush; 0 disables auto-flush.
REQ-005 SHALL have ports, one per line (clock and reset first):
- clk  in  1  clock; one clock domain only.
- reset_i  in  1  asynchronous, active-high reset.
- pix_valid_i  in  1  pixel write valid.
- pix_ready_o  out  1  pixel write ready.
- pix_addr_i  in  ADDR_WIDTH  pixel address.
- pix_data_i  in  PIXEL_WIDTH  pixel data.
- swap_req_i  in  1  buffer-swap request (level sampled per cycle).
- swap_o  out  1  one-cycle swap pulse, issued after flush.
- vram_sel_o  out  1  VRAM select.
- vram_wr_o  out  1  VRAM write strobe.
- vram_mask_o  out  PPW  per-lane write enable.
- vram_addr_o  out  ADDR_WIDTH-L  word address.
- vram_data_out_o  out  VRAM_DATA_WIDTH  word data; lane i = bits [i*PIXEL_WIDTH +: PIXEL_WIDTH].
- vram_ack_i  in  1  VRAM write accepted.
- busy_o  out  1  write or swap outstanding.

Function
REQ-006 SHALL hold one accumulator (word address, data, mask) with FSM states EMPTY, ACCUM, WRITE, SWAP.
REQ-007 Transfer SHALL occur when pix_valid_i and pix_ready_o are both high at a rising edge; word = pix_addr_i[ADDR_WIDTH-1:L]; lane = pix_addr_i[L-1:0].
REQ-008 pix_ready_o SHALL be 1 in EMPTY, and 1 in ACCUM only when pix_valid_i is low or the word matches the accumulator; it SHALL be 0 in WRITE and SWAP and whenever a swap is pending.
REQ-009 EMPTY + transfer: load the word, write the lane data, set mask to one-hot lane, clear the other lanes to zero, go to ACCUM.
REQ-010 ACCUM + same-word transfer: write the lane data and set the lane mask bit; a repeated lane overwrites the earlier data. If the mask becomes all ones, go to WRITE on the next cycle.
REQ-011 ACCUM with valid different-word pixel: no transfer, go to WRITE; the pixel is accepted after the write completes.
REQ-012 ACCUM idle counter: reset on every transfer; after FLUSH_TIMEOUT consecutive cycles without a transfer, go to WRITE.
REQ-013 WRITE: vram_sel_o = vram_wr_o = 1; address, data and mask SHALL be held stable until vram_ack_i is sampled high. On ack, clear the accumulator and go to EMPTY, or to SWAP if a swap is pending.
REQ-014 swap_req_i high in any state SHALL set swap_pending; further requests while pending SHALL be merged. Resulting transitions: ACCUM goes to WRITE; EMPTY goes to SWAP.
REQ-015 SWAP: assert swap_o for exactly one cycle, clear swap_pending, go to EMPTY.
REQ-016 Latency: the write strobe SHALL be asserted in the cycle after the transfer that fills the mask; swap_o SHALL be asserted in the cycle after an ack that completes a flush.
REQ-017 vram_sel_o and vram_wr_o SHALL be 0 outside WRITE.
REQ-018 busy_o SHALL be 1 when the state is not EMPTY or swap_pending is set.

Reset
REQ-019 reset_i SHALL asynchronously force: state EMPTY, accumulator and mask 0, counter 0, swap_pending 0.
REQ-020 During reset, all outputs SHALL be 0, including pix_ready_o.
REQ-021 Reset during WRITE SHALL abandon the write with no retry.

Structure
REQ-022 The FSM state enum typedef and the default parameter constants SHALL live in package graphite_pkg.
REQ-023 The block SHALL be a single module with no sub-modules; lane insertion SHALL be a function.

Verification (PPW=4)
REQ-024 Pixels 0x0010..0x0013 with data 0xA000..0xA003 back-to-back, ack delayed 3 cycles -> one write: addr 0x0004, mask 0xF, data 0xA003A002A001A000, held stable until ack.
REQ-025 Pixel 0x0021=0xBEEF, then 0x0030 presented -> write addr 0x0008, mask 0x2, data 0x00000000BEEF0000; 0x0030 held off until ack, then accepted.
REQ-026 Single pixel 0x0000, then idle -> write strobe rises exactly 15 cycles after the transfer.
REQ-027 Pixel 0x0005=0x1111, then 0x0005=0x2222, then swap_req_i -> write mask 0x2, lane1 0x2222; swap_o pulses one cycle after ack; pix_ready_o low from the request until after the pulse.
REQ-028 swap_req_i in EMPTY -> swap_o pulses on the next cycle; no VRAM write.
REQ-029 reset_i asserted mid-WRITE -> vram_wr_o drops immediately; after release the FSM is EMPTY and busy_o is 0.

Source files
------------

// File: rtl/graphite_pkg.sv
// Shared types and default parameter values for the VRAM write coalescer.
package graphite_pkg;

   // Coalescer FSM states.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ACCUM = 2'd1,
      ST_WRITE = 2'd2,
      ST_SWAP  = 2'd3
   } state_e;

   localparam int DEF_ADDR_WIDTH      = 16;
   localparam int DEF_PIXEL_WIDTH     = 16;
   localparam int DEF_VRAM_DATA_WIDTH = 64;
   localparam int DEF_FLUSH_TIMEOUT   = 15;

endpackage

// File: rtl/vram_write_coalescer_if.sv
// Bundle of the coalescer's pixel, swap and VRAM signals.
// Pixel handshake: a pixel moves when pix_valid and pix_ready are both high
// at a rising clock edge; the producer keeps addr/data stable while valid is
// high and not yet accepted. VRAM handshake: vram_wr stays high with
// address/mask/data held until vram_ack is sampled high.
interface vram_write_coalescer_if
   import graphite_pkg::*;
#(
   parameter int ADDR_WIDTH      = DEF_ADDR_WIDTH,
   parameter int PIXEL_WIDTH     = DEF_PIXEL_WIDTH,
   parameter int VRAM_DATA_WIDTH = DEF_VRAM_DATA_WIDTH
);
   localparam int PPW = VRAM_DATA_WIDTH / PIXEL_WIDTH;
   localparam int L   = $clog2(PPW);

   logic                       pix_valid;
   logic                       pix_ready;
   logic [ADDR_WIDTH-1:0]      pix_addr;
   logic [PIXEL_WIDTH-1:0]     pix_data;
   logic                       swap_req;
   logic                       swap;
   logic                       vram_sel;
   logic                       vram_wr;
   logic [PPW-1:0]             vram_mask;
   logic [ADDR_WIDTH-L-1:0]    vram_addr;
   logic [VRAM_DATA_WIDTH-1:0] vram_data;
   logic                       vram_ack;
   logic                       busy;

   // Pixel producer / VRAM responder side.
   modport master (
      output pix_valid, pix_addr, pix_data, swap_req, vram_ack,
      input  pix_ready, swap, vram_sel, vram_wr, vram_mask, vram_addr,
             vram_data, busy
   );

   // Coalescer side.
   modport slave (
      input  pix_valid, pix_addr, pix_data, swap_req, vram_ack,
      output pix_ready, swap, vram_sel, vram_wr, vram_mask, vram_addr,
             vram_data, busy
   );

endinterface

// File: rtl/vram_write_coalescer.sv
// Gathers pixel writes that fall into the same VRAM word into one masked
// word write, flushing on word change, full mask, idle timeout or swap.
module vram_write_coalescer
   import graphite_pkg::*;
#(
   parameter int ADDR_WIDTH      = DEF_ADDR_WIDTH,
   parameter int PIXEL_WIDTH     = DEF_PIXEL_WIDTH,
   parameter int VRAM_DATA_WIDTH = DEF_VRAM_DATA_WIDTH,
   parameter int FLUSH_TIMEOUT   = DEF_FLUSH_TIMEOUT
) (
   input  logic                                  clk,
   input  logic                                  reset_i,
   input  logic                                  pix_valid_i,
   output logic                                  pix_ready_o,
   input  logic [ADDR_WIDTH-1:0]                 pix_addr_i,
   input  logic [PIXEL_WIDTH-1:0]                pix_data_i,
   input  logic                                  swap_req_i,
   output logic                                  swap_o,
   output logic                                  vram_sel_o,
   output logic                                  vram_wr_o,
   output logic [VRAM_DATA_WIDTH/PIXEL_WIDTH-1:0] vram_mask_o,
   output logic [ADDR_WIDTH-$clog2(VRAM_DATA_WIDTH/PIXEL_WIDTH)-1:0] vram_addr_o,
   output logic [VRAM_DATA_WIDTH-1:0]            vram_data_out_o,
   input  logic                                  vram_ack_i,
   output logic                                  busy_o
);

   localparam int PPW = VRAM_DATA_WIDTH / PIXEL_WIDTH;
   localparam int L   = $clog2(PPW);
   localparam int WW  = ADDR_WIDTH - L;
   localparam int CW  = (FLUSH_TIMEOUT < 2) ? 1 : $clog2(FLUSH_TIMEOUT + 1);

   state_e                     state_q, state_d;
   logic [WW-1:0]              word_q, word_d;
   logic [VRAM_DATA_WIDTH-1:0] data_q, data_d;
   logic [PPW-1:0]             mask_q, mask_d;
   logic [CW-1:0]              cnt_q, cnt_d;
   logic                       swap_pend_q, swap_pend_d;

   logic [WW-1:0]              in_word;
   logic [L-1:0]               in_lane;
   logic [PPW-1:0]             lane_bit;
   logic                       swap_now;
   logic                       ready_raw;
   logic                       xfer;

   // Replace one pixel lane of a VRAM word, leaving the other lanes intact.
   function automatic logic [VRAM_DATA_WIDTH-1:0] insert_lane(
      input logic [VRAM_DATA_WIDTH-1:0] word,
      input logic [L-1:0]               lane,
      input logic [PIXEL_WIDTH-1:0]     pix
   );
      logic [VRAM_DATA_WIDTH-1:0] r;
      r = word;
      r[int'(lane)*PIXEL_WIDTH +: PIXEL_WIDTH] = pix;
      return r;
   endfunction

   assign in_word  = pix_addr_i[ADDR_WIDTH-1:L];
   assign in_lane  = pix_addr_i[L-1:0];
   assign lane_bit = PPW'(1) << in_lane;

   // A swap request in this cycle already counts as pending, so no pixel can
   // slip in between the request and the flush it triggers.
   assign swap_now = swap_pend_q | swap_req_i;

   // Pixel acceptance: always in EMPTY, in ACCUM only for the held word.
   always_comb begin
      ready_raw = 1'b0;
      case (state_q)
         ST_EMPTY: ready_raw = 1'b1;
         ST_ACCUM: ready_raw = !pix_valid_i || (in_word == word_q);
         default:  ready_raw = 1'b0;
      endcase
   end

   assign pix_ready_o = ready_raw && !swap_now && !reset_i;
   assign xfer        = pix_valid_i && pix_ready_o;

   // Next-state and accumulator update.
   always_comb begin
      state_d     = state_q;
      word_d      = word_q;
      data_d      = data_q;
      mask_d      = mask_q;
      cnt_d       = cnt_q;
      swap_pend_d = swap_now;
      case (state_q)
         ST_EMPTY: begin
            if (xfer) begin
               word_d  = in_word;
               data_d  = insert_lane('0, in_lane, pix_data_i);
               mask_d  = lane_bit;
               cnt_d   = '0;
               state_d = ST_ACCUM;
            end else if (swap_now) begin
               state_d = ST_SWAP;
            end
         end
         ST_ACCUM: begin
            if (xfer) begin
               data_d = insert_lane(data_q, in_lane, pix_data_i);
               mask_d = mask_q | lane_bit;
               cnt_d  = '0;
               if (&mask_d) state_d = ST_WRITE;
            end else if (pix_valid_i || swap_now) begin
               // Different word waiting, or a swap needs the flush first.
               state_d = ST_WRITE;
            end else begin
               cnt_d = cnt_q + 1'b1;
               if (FLUSH_TIMEOUT != 0 && cnt_d == CW'(FLUSH_TIMEOUT)) state_d = ST_WRITE;
            end
         end
         ST_WRITE: begin
            if (vram_ack_i) begin
               word_d  = '0;
               data_d  = '0;
               mask_d  = '0;
               cnt_d   = '0;
               state_d = swap_now ? ST_SWAP : ST_EMPTY;
            end
         end
         ST_SWAP: begin
            swap_pend_d = 1'b0;
            state_d     = ST_EMPTY;
         end
         default: state_d = ST_EMPTY;
      endcase
   end

   // State and accumulator registers; reset abandons any write in flight.
   always_ff @(posedge clk or posedge reset_i) begin
      if (reset_i) begin
         state_q     <= ST_EMPTY;
         word_q      <= '0;
         data_q      <= '0;
         mask_q      <= '0;
         cnt_q       <= '0;
         swap_pend_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         word_q      <= word_d;
         data_q      <= data_d;
         mask_q      <= mask_d;
         cnt_q       <= cnt_d;
         swap_pend_q <= swap_pend_d;
      end
   end

   assign vram_sel_o      = (state_q == ST_WRITE);
   assign vram_wr_o       = (state_q == ST_WRITE);
   assign vram_addr_o     = word_q;
   assign vram_data_out_o = data_q;
   assign vram_mask_o     = mask_q;
   assign swap_o          = (state_q == ST_SWAP);
   assign busy_o          = (state_q != ST_EMPTY) || swap_pend_q;

endmodule

// File: tb/tb_vram_write_coalescer.sv
// Self-checking bench for vram_write_coalescer with 4 pixels per VRAM word.
module tb_vram_write_coalescer;

   localparam int EW = 14 + 4 + 64;

   logic clk;
   logic rst;

   vram_write_coalescer_if bus ();

   vram_write_coalescer dut (
      .clk             (clk),
      .reset_i         (rst),
      .pix_valid_i     (bus.pix_valid),
      .pix_ready_o     (bus.pix_ready),
      .pix_addr_i      (bus.pix_addr),
      .pix_data_i      (bus.pix_data),
      .swap_req_i      (bus.swap_req),
      .swap_o          (bus.swap),
      .vram_sel_o      (bus.vram_sel),
      .vram_wr_o       (bus.vram_wr),
      .vram_mask_o     (bus.vram_mask),
      .vram_addr_o     (bus.vram_addr),
      .vram_data_out_o (bus.vram_data),
      .vram_ack_i      (bus.vram_ack),
      .busy_o          (bus.busy)
   );

   // Clock and cycle counter
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;

   logic [EW-1:0] exp_q[$];
   logic [EW-1:0] got_q[$];

   // VRAM responder: acks after a delay and logs each accepted write
   int            ack_delay = 0;
   bit            rand_ack  = 1'b0;
   int            wait_cnt  = 0;
   int            cur_delay = 0;
   int            last_ack_cyc = -10;
   logic [EW-1:0] held;
   logic [EW-1:0] cur;

   always @(negedge clk) begin
      cur = {bus.vram_addr, bus.vram_mask, bus.vram_data};
      if (rst) begin
         bus.vram_ack = 1'b0;
         wait_cnt     = 0;
      end else if (bus.vram_wr) begin
         if (wait_cnt == 0) begin
            cur_delay = rand_ack ? int'($urandom_range(0, 3)) : ack_delay;
            held      = cur;
         end else begin
            n_checks++;
            if (cur !== held) begin
               n_fail++;
               $display("FAIL write_hold_stable: got %h expected %h", cur, held);
            end
         end
         if (wait_cnt == cur_delay) begin
            bus.vram_ack = 1'b1;
            got_q.push_back(cur);
            last_ack_cyc = cyc;
         end else begin
            bus.vram_ack = 1'b0;
         end
         wait_cnt++;
      end else begin
         bus.vram_ack = 1'b0;
         wait_cnt     = 0;
      end
   end

   function automatic logic [EW-1:0] pack(input logic [13:0] a, input logic [3:0] m,
                                          input logic [63:0] d);
      return {a, m, d};
   endfunction

   // Driver: present one pixel (called at a negedge) and return at the
   // negedge after it was accepted, with valid still high.
   task automatic send_pix(input logic [15:0] a, input logic [15:0] d);
      int budget;
      budget = 0;
      bus.pix_valid = 1'b1;
      bus.pix_addr  = a;
      bus.pix_data  = d;
      #1;
      while (!bus.pix_ready && budget < 200) begin
         @(negedge clk);
         #1;
         budget++;
      end
      if (!bus.pix_ready) begin
         n_checks++;
         n_fail++;
         $display("FAIL send_timeout: pixel %h never accepted", a);
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic wait_writes(input int n);
      int budget;
      budget = 0;
      while (got_q.size() < n && budget < 300) begin
         @(negedge clk);
         budget++;
      end
      n_checks++;
      if (got_q.size() < n) begin
         n_fail++;
         $display("FAIL write_count: got %0d expected %0d", got_q.size(), n);
      end
   endtask

   task automatic test_reset();
      rst           = 1'b1;
      bus.pix_valid = 1'b1;
      bus.pix_addr  = 16'h0000;
      bus.pix_data  = 16'h0000;
      bus.swap_req  = 1'b0;
      #12;
      n_checks++;
      if (bus.pix_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %b expected 0", bus.pix_ready); end
      n_checks++;
      if ({bus.vram_sel, bus.vram_wr, bus.swap, bus.busy} !== 4'b0000) begin
         n_fail++; $display("FAIL rst_ctrl: got %b expected 0000", {bus.vram_sel, bus.vram_wr, bus.swap, bus.busy});
      end
      n_checks++;
      if ({bus.vram_addr, bus.vram_mask, bus.vram_data} !== '0) begin
         n_fail++; $display("FAIL rst_bus: got %h expected 0", {bus.vram_addr, bus.vram_mask, bus.vram_data});
      end
      @(negedge clk);
      @(negedge clk);
      bus.pix_valid = 1'b0;
      rst           = 1'b0;
      #1;
      n_checks++;
      if (bus.pix_ready !== 1'b1 || bus.busy !== 1'b0) begin
         n_fail++; $display("FAIL post_rst_idle: got ready=%b busy=%b expected 1/0", bus.pix_ready, bus.busy);
      end
      @(negedge clk);
   endtask

   task automatic test_full_word();
      got_q.delete();
      rand_ack  = 1'b0;
      ack_delay = 3;
      for (int i = 0; i < 4; i++) send_pix(16'h0010 + 16'(i), 16'hA000 + 16'(i));
      bus.pix_valid = 1'b0;
      #1;
      n_checks++;
      if (bus.vram_wr !== 1'b1 || bus.vram_sel !== 1'b1) begin
         n_fail++; $display("FAIL full_wr_latency: got wr=%b sel=%b expected 1/1", bus.vram_wr, bus.vram_sel);
      end
      wait_writes(1);
      n_checks++;
      if (got_q.size() < 1 || got_q[0] !== pack(14'h0004, 4'hF, 64'hA003A002A001A000)) begin
         n_fail++; $display("FAIL full_word: got %h expected %h", (got_q.size() > 0) ? got_q[0] : '0,
                            pack(14'h0004, 4'hF, 64'hA003A002A001A000));
      end
      repeat (3) @(negedge clk);
      #1;
      n_checks++;
      if (bus.busy !== 1'b0 || got_q.size() != 1) begin
         n_fail++; $display("FAIL full_after: got busy=%b writes=%0d expected 0/1", bus.busy, got_q.size());
      end
   endtask

   task automatic test_word_change();
      got_q.delete();
      ack_delay = 1;
      send_pix(16'h0021, 16'hBEEF);
      bus.pix_addr = 16'h0030;
      bus.pix_data = 16'h1234;
      #1;
      n_checks++;
      if (bus.pix_ready !== 1'b0) begin n_fail++; $display("FAIL change_holdoff: got ready=%b expected 0", bus.pix_ready); end
      send_pix(16'h0030, 16'h1234);
      bus.pix_valid = 1'b0;
      n_checks++;
      if (got_q.size() != 1) begin
         n_fail++; $display("FAIL change_order: got %0d writes before accept expected 1", got_q.size());
      end
      wait_writes(2);
      n_checks++;
      if (got_q.size() < 1 || got_q[0] !== pack(14'h0008, 4'h2, 64'h00000000BEEF0000)) begin
         n_fail++; $display("FAIL change_first: got %h expected %h", (got_q.size() > 0) ? got_q[0] : '0,
                            pack(14'h0008, 4'h2, 64'h00000000BEEF0000));
      end
      n_checks++;
      if (got_q.size() < 2 || got_q[1] !== pack(14'h000C, 4'h1, 64'h0000000000001234)) begin
         n_fail++; $display("FAIL change_second: got %h expected %h", (got_q.size() > 1) ? got_q[1] : '0,
                            pack(14'h000C, 4'h1, 64'h0000000000001234));
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_timeout();
      int k;
      got_q.delete();
      ack_delay = 0;
      send_pix(16'h0000, 16'h5A5A);
      bus.pix_valid = 1'b0;
      k = 0;
      #1;
      while (!bus.vram_wr && k < 40) begin
         @(negedge clk);
         k++;
         #1;
      end
      n_checks++;
      if (k != 15) begin n_fail++; $display("FAIL timeout_cycles: got %0d expected 15", k); end
      wait_writes(1);
      n_checks++;
      if (got_q.size() < 1 || got_q[0] !== pack(14'h0000, 4'h1, 64'h0000000000005A5A)) begin
         n_fail++; $display("FAIL timeout_word: got %h expected %h", (got_q.size() > 0) ? got_q[0] : '0,
                            pack(14'h0000, 4'h1, 64'h0000000000005A5A));
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_swap_after_accum();
      int pulses, pulse_cyc, rdy_bad;
      bit after_seen;
      logic rdy_after;
      got_q.delete();
      ack_delay  = 2;
      pulses     = 0;
      pulse_cyc  = -1;
      rdy_bad    = 0;
      after_seen = 1'b0;
      rdy_after  = 1'b0;
      send_pix(16'h0005, 16'h1111);
      send_pix(16'h0005, 16'h2222);
      bus.pix_valid = 1'b0;
      bus.swap_req  = 1'b1;
      #1;
      n_checks++;
      if (bus.pix_ready !== 1'b0) begin n_fail++; $display("FAIL swap_req_ready: got %b expected 0", bus.pix_ready); end
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         bus.swap_req = 1'b0;
         #1;
         if (bus.swap) begin
            pulses++;
            pulse_cyc = cyc;
         end else if (pulses > 0 && !after_seen) begin
            after_seen = 1'b1;
            rdy_after  = bus.pix_ready;
         end
         if ((pulses == 0 || bus.swap) && bus.pix_ready) rdy_bad++;
      end
      n_checks++;
      if (got_q.size() != 1 || got_q[0] !== pack(14'h0001, 4'h2, 64'h0000000022220000)) begin
         n_fail++; $display("FAIL swap_flush_word: got %h (n=%0d) expected %h", (got_q.size() > 0) ? got_q[0] : '0,
                            got_q.size(), pack(14'h0001, 4'h2, 64'h0000000022220000));
      end
      n_checks++;
      if (pulses != 1) begin n_fail++; $display("FAIL swap_pulses: got %0d expected 1", pulses); end
      n_checks++;
      if (pulse_cyc != last_ack_cyc + 1) begin
         n_fail++; $display("FAIL swap_latency: got cycle %0d expected %0d", pulse_cyc, last_ack_cyc + 1);
      end
      n_checks++;
      if (rdy_bad != 0 || rdy_after !== 1'b1) begin
         n_fail++; $display("FAIL swap_ready: got %0d early-ready cycles, ready after=%b expected 0/1", rdy_bad, rdy_after);
      end
   endtask

   task automatic test_swap_empty();
      got_q.delete();
      bus.swap_req = 1'b1;
      @(negedge clk);
      bus.swap_req = 1'b0;
      #1;
      n_checks++;
      if (bus.swap !== 1'b1 || bus.vram_wr !== 1'b0) begin
         n_fail++; $display("FAIL empty_swap: got swap=%b wr=%b expected 1/0", bus.swap, bus.vram_wr);
      end
      @(negedge clk);
      #1;
      n_checks++;
      if (bus.swap !== 1'b0 || bus.busy !== 1'b0 || got_q.size() != 0) begin
         n_fail++; $display("FAIL empty_swap_after: got swap=%b busy=%b writes=%0d expected 0/0/0",
                            bus.swap, bus.busy, got_q.size());
      end
   endtask

   task automatic test_reset_mid_write();
      int wr_seen;
      got_q.delete();
      ack_delay = 1000;
      wr_seen   = 0;
      for (int i = 0; i < 4; i++) send_pix(16'h0040 + 16'(i), 16'hC0DE + 16'(i));
      #1;
      n_checks++;
      if (bus.vram_wr !== 1'b1) begin n_fail++; $display("FAIL mid_write_start: got wr=%b expected 1", bus.vram_wr); end
      #1;
      rst = 1'b1;
      #1;
      n_checks++;
      if ({bus.vram_wr, bus.vram_sel, bus.pix_ready, bus.busy, bus.swap} !== 5'b00000) begin
         n_fail++; $display("FAIL mid_write_rst: got %b expected 00000",
                            {bus.vram_wr, bus.vram_sel, bus.pix_ready, bus.busy, bus.swap});
      end
      @(negedge clk);
      @(negedge clk);
      bus.pix_valid = 1'b0;
      rst           = 1'b0;
      #1;
      n_checks++;
      if (bus.busy !== 1'b0 || bus.pix_ready !== 1'b1) begin
         n_fail++; $display("FAIL mid_write_release: got busy=%b ready=%b expected 0/1", bus.busy, bus.pix_ready);
      end
      for (int i = 0; i < 25; i++) begin
         @(negedge clk);
         #1;
         if (bus.vram_wr) wr_seen++;
      end
      n_checks++;
      if (wr_seen != 0 || got_q.size() != 0) begin
         n_fail++; $display("FAIL mid_write_retry: got %0d wr cycles, %0d writes expected 0/0", wr_seen, got_q.size());
      end
      ack_delay = 0;
   endtask

   // Random pixel stream against a word-grouping model of coalescing.
   task automatic test_random();
      logic [15:0] pa[64];
      logic [15:0] pd[64];
      logic [13:0] w, cur_w;
      logic [1:0]  l;
      logic [63:0] acc;
      logic [3:0]  m;
      bit          have;
      got_q.delete();
      exp_q.delete();
      rand_ack = 1'b1;
      w = 14'h0100;
      for (int i = 0; i < 64; i++) begin
         if ($urandom_range(0, 3) == 0) w = 14'h0100 + 14'($urandom_range(0, 2));
         pa[i] = {w, 2'($urandom_range(0, 3))};
         pd[i] = 16'($urandom);
      end
      have  = 1'b0;
      cur_w = '0;
      acc   = '0;
      m     = '0;
      for (int i = 0; i < 64; i++) begin
         w = pa[i][15:2];
         l = pa[i][1:0];
         if (have && w != cur_w) begin
            exp_q.push_back(pack(cur_w, m, acc));
            have = 1'b0;
         end
         if (!have) begin
            have  = 1'b1;
            cur_w = w;
            acc   = '0;
            m     = '0;
         end
         acc[l*16 +: 16] = pd[i];
         m[l] = 1'b1;
         if (m == 4'hF) begin
            exp_q.push_back(pack(cur_w, m, acc));
            have = 1'b0;
         end
      end
      if (have) exp_q.push_back(pack(cur_w, m, acc));
      for (int i = 0; i < 64; i++) send_pix(pa[i], pd[i]);
      bus.pix_valid = 1'b0;
      wait_writes(exp_q.size());
      repeat (5) @(negedge clk);
      n_checks++;
      if (got_q.size() != exp_q.size()) begin
         n_fail++; $display("FAIL rand_count: got %0d expected %0d", got_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size(); i++) begin
         n_checks++;
         if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
            n_fail++; $display("FAIL rand_write[%0d]: got %h expected %h", i,
                               (i < got_q.size()) ? got_q[i] : '0, exp_q[i]);
         end
      end
      rand_ack = 1'b0;
   endtask

   initial begin
      bus.vram_ack = 1'b0;
      test_reset();
      test_full_word();
      test_word_change();
      test_timeout();
      test_swap_after_accum();
      test_swap_empty();
      test_reset_mid_write();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      n_fail++;
      $display("FAIL watchdog: simulation did not complete");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $fatal(1, "watchdog expired");
   end

endmodule
